// File: rtl/slice_fcarry_cfgreg.sv
// rtl/slice_fcarry_cfgreg.sv - Fracturable LUT slice with mux carry chain and double-buffered serial config
module slice_fcarry_cfgreg #(
    parameter int LUT_INPUTS = 4,
    parameter int NUM_LUTS   = 4,
    parameter int LUT_CFG    = 2**LUT_INPUTS + 2,
    parameter int CFG_BITS   = NUM_LUTS*LUT_CFG + 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [LUT_INPUTS*NUM_LUTS-1:0] luts_in,
    input  logic                           ci,
    input  logic                           ce,
    input  logic                           cfg_in,
    input  logic                           cfg_shift,
    input  logic                           cfg_commit,
    output logic                           cfg_out,
    output logic [NUM_LUTS-1:0]            comb_out,
    output logic [NUM_LUTS-1:0]            sec_out,
    output logic [NUM_LUTS-1:0]            reg_out,
    output logic                           co,
    output logic                           cfg_done,
    output logic                           cfg_err
);
    localparam int TT = 2**LUT_INPUTS;
    localparam int CW = $clog2(CFG_BITS + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(CFG_BITS);

    typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} load_state_t;

    load_state_t         state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [CFG_BITS-1:0] shadow_q;
    logic [CFG_BITS-1:0] active_q;
    logic                commit_ok;
    logic [NUM_LUTS-1:0] init_vec;
    logic [NUM_LUTS:0]   carry;

    // Load state tracks the counter; a commit racing a shift is never legal.
    always_comb begin
        cnt_d     = cnt_q;
        state_d   = state_q;
        commit_ok = cfg_commit && !cfg_shift && (state_q == FULL);
        if (commit_ok) begin
            cnt_d = '0;
        end else if (cfg_shift && (cnt_q != CNT_FULL)) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (cnt_d == '0) begin
            state_d = EMPTY;
        end else if (cnt_d == CNT_FULL) begin
            state_d = FULL;
        end else begin
            state_d = PARTIAL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= EMPTY;
            cnt_q    <= '0;
            shadow_q <= '0;
            active_q <= '0;
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (cfg_shift) begin
                shadow_q <= {cfg_in, shadow_q[CFG_BITS-1:1]};
            end
            if (commit_ok) begin
                active_q <= shadow_q;
                cfg_done <= 1'b1;
                cfg_err  <= 1'b0;
            end else if (cfg_commit) begin
                cfg_err  <= 1'b1;
            end
        end
    end

    assign cfg_out = shadow_q[0];

    always_comb begin
        init_vec = '0;
        for (int i = 0; i < NUM_LUTS; i++) begin
            init_vec[i] = shadow_q[i*LUT_CFG + TT + 1];
        end
    end

    // Carry mode uses the upper half as propagate and the lower half as generate.
    always_comb begin : lut_eval
        logic [TT-1:0]         truth;
        logic                  frac;
        logic [LUT_INPUTS-1:0] addr;
        logic [LUT_INPUTS-2:0] low_addr;
        logic                  full;
        logic                  hi;
        logic                  lo;
        comb_out = '0;
        sec_out  = '0;
        carry    = '0;
        carry[0] = ci;
        for (int i = 0; i < NUM_LUTS; i++) begin
            truth    = active_q[i*LUT_CFG +: TT];
            frac     = active_q[i*LUT_CFG + TT];
            addr     = luts_in[LUT_INPUTS*i +: LUT_INPUTS];
            low_addr = addr[LUT_INPUTS-2:0];
            full     = truth[addr];
            hi       = truth[{1'b1, low_addr}];
            lo       = truth[{1'b0, low_addr}];
            if (active_q[CFG_BITS-1]) begin
                comb_out[i]  = hi ^ carry[i];
                sec_out[i]   = lo;
                carry[i+1]   = hi ? carry[i] : lo;
            end else begin
                comb_out[i]  = frac ? hi : full;
                sec_out[i]   = frac ? lo : 1'b0;
                carry[i+1]   = 1'b0;
            end
        end
        co = active_q[CFG_BITS-1] ? carry[NUM_LUTS] : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_out <= '0;
        end else if (commit_ok) begin
            reg_out <= init_vec;
        end else if (ce) begin
            reg_out <= comb_out;
        end
    end
endmodule

// File: tb/tb_slice_fcarry_cfgreg.sv
// tb/tb_slice_fcarry_cfgreg.sv - Directed and randomized bench against a field-level slice model
module tb_slice_fcarry_cfgreg;
    localparam int K  = 4;
    localparam int N  = 4;
    localparam int LC = 18;
    localparam int CB = 73;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, ci = 1'b0, ce = 1'b0;
    logic        cfg_in = 1'b0, cfg_shift = 1'b0, cfg_commit = 1'b0;
    logic [15:0] luts_in = '0;
    logic        cfg_out, co, cfg_done, cfg_err;
    logic [3:0]  comb_out, sec_out, reg_out;

    slice_fcarry_cfgreg #(.LUT_INPUTS(K), .NUM_LUTS(N)) dut (
        .clk(clk), .rst(rst), .luts_in(luts_in), .ci(ci), .ce(ce),
        .cfg_in(cfg_in), .cfg_shift(cfg_shift), .cfg_commit(cfg_commit),
        .cfg_out(cfg_out), .comb_out(comb_out), .sec_out(sec_out),
        .reg_out(reg_out), .co(co), .cfg_done(cfg_done), .cfg_err(cfg_err)
    );

    int checks = 0;
    int fails  = 0;

    // Reference state: shadow as a bit queue (front = scan-out end), active as decoded fields.
    bit        shq[$];
    int        m_cnt;
    bit [15:0] m_truth[N];
    bit        m_frac[N];
    bit        m_init[N];
    bit        m_cc;
    bit [3:0]  m_reg;
    bit        m_done, m_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        shq.delete();
        repeat (CB) shq.push_back(1'b0);
        m_cnt = 0;
        for (int i = 0; i < N; i++) begin
            m_truth[i] = '0; m_frac[i] = 1'b0; m_init[i] = 1'b0;
        end
        m_cc = 1'b0; m_reg = '0; m_done = 1'b0; m_err = 1'b0;
    endtask

    function automatic void m_eval(input logic [15:0] lin, input logic cin,
                                   output bit [3:0] cmb, output bit [3:0] sc, output bit cout);
        int a, l;
        bit full, hi, lo, c;
        c = cin; cmb = '0; sc = '0;
        for (int i = 0; i < N; i++) begin
            a    = int'(lin[4*i +: 4]);
            l    = a % 8;
            full = m_truth[i][a];
            hi   = m_truth[i][8 + l];
            lo   = m_truth[i][l];
            if (m_cc) begin
                cmb[i] = hi ^ c;
                sc[i]  = lo;
                if (!hi) c = lo;
            end else begin
                cmb[i] = m_frac[i] ? hi : full;
                sc[i]  = m_frac[i] ? lo : 1'b0;
            end
        end
        cout = m_cc ? c : 1'b0;
    endfunction

    task automatic step();
        bit [3:0] ec, es;
        bit       eco;
        m_eval(luts_in, ci, ec, es, eco);
        if (rst) begin
            model_reset();
        end else if (cfg_commit && !cfg_shift && m_cnt == CB) begin
            for (int i = 0; i < N; i++) begin
                for (int b = 0; b < 16; b++) m_truth[i][b] = shq[i*LC + b];
                m_frac[i] = shq[i*LC + 16];
                m_init[i] = shq[i*LC + 17];
                m_reg[i]  = m_init[i];
            end
            m_cc = shq[CB-1];
            m_cnt = 0; m_done = 1'b1; m_err = 1'b0;
        end else begin
            if (cfg_commit) m_err = 1'b1;
            if (ce) m_reg = ec;
            if (cfg_shift) begin
                shq.push_back(cfg_in);
                void'(shq.pop_front());
                if (m_cnt < CB) m_cnt++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag);
        bit [3:0] ec, es;
        bit       eco;
        #1;
        m_eval(luts_in, ci, ec, es, eco);
        chk({tag, ".comb"}, comb_out, ec);
        chk({tag, ".sec"},  sec_out,  es);
        chk({tag, ".co"},   co,       eco);
        chk({tag, ".reg"},  reg_out,  m_reg);
        chk({tag, ".scan"}, cfg_out,  shq[0]);
        chk({tag, ".done"}, cfg_done, m_done);
        chk({tag, ".err"},  cfg_err,  m_err);
    endtask

    task automatic do_shift(input logic b);
        cfg_in = b; cfg_shift = 1'b1;
        step();
        cfg_shift = 1'b0;
    endtask

    task automatic do_commit();
        cfg_commit = 1'b1;
        step();
        cfg_commit = 1'b0;
    endtask

    task automatic load(input logic [CB-1:0] v);
        for (int j = 0; j < CB; j++) do_shift(v[j]);
    endtask

    function automatic logic [CB-1:0] fld(input int i, input logic [15:0] t, input logic fr, input logic in);
        logic [CB-1:0] v;
        v = '0;
        v[i*LC +: LC] = {in, fr, t};
        return v;
    endfunction

    task automatic add_case(input logic [3:0] a, input logic [3:0] b, input logic c);
        logic [4:0] sum;
        for (int i = 0; i < N; i++) luts_in[4*i +: 4] = {2'b00, b[i], a[i]};
        ci = c;
        #1;
        sum = 5'(a) + 5'(b) + 5'(c);
        chk("add.sum", comb_out, sum[3:0]);
        chk("add.co",  co,       sum[4]);
        chk_all("add");
    endtask

    logic [CB-1:0] v, v_add;
    logic          first_bit;

    initial begin
        model_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int r = 0; r < 4; r++) begin
            luts_in = 16'($urandom); ci = 1'($urandom);
            #1;
            chk("reset.comb", comb_out, 4'h0);
            chk("reset.co",   co,       1'b0);
            chk("reset.reg",  reg_out,  4'h0);
            chk_all("reset");
        end

        for (int j = 0; j < 10; j++) do_shift(1'($urandom));
        do_commit();
        chk("early.err",  cfg_err,  1'b1);
        chk("early.done", cfg_done, 1'b0);
        chk("early.comb", comb_out, 4'h0);
        for (int j = 0; j < 63; j++) do_shift(1'($urandom));
        do_commit();
        chk("full.err",  cfg_err,  1'b0);
        chk("full.done", cfg_done, 1'b1);
        chk_all("full");

        load(fld(0, 16'h8000, 1'b0, 1'b0));
        do_commit();
        ce = 1'b0; luts_in = 16'h000F;
        #1;
        chk("lut0.hit", comb_out[0], 1'b1);
        luts_in = 16'h000E;
        #1;
        chk("lut0.miss", comb_out[0], 1'b0);
        luts_in = 16'h000F; ce = 1'b1;
        step();
        chk("lut0.reg", reg_out[0], 1'b1);
        ce = 1'b0; luts_in = 16'h000E;
        step();
        chk("lut0.hold", reg_out[0], 1'b1);
        chk_all("lut0");

        v_add = '0;
        for (int i = 0; i < N; i++) v_add |= fld(i, 16'h6688, 1'b0, 1'b0);
        v_add[CB-1] = 1'b1;
        load(v_add);
        do_commit();
        add_case(4'b0111, 4'b0001, 1'b0);
        add_case(4'b1111, 4'b0001, 1'b0);
        add_case(4'b0000, 4'b0000, 1'b1);
        for (int r = 0; r < 16; r++) add_case(4'($urandom), 4'($urandom), 1'($urandom));

        v = '0;
        for (int i = 0; i < N; i++) v |= fld(i, 16'h0000, 1'b0, 1'b1);
        load(v);
        ce = 1'b0;
        do_commit();
        chk("init.reg", reg_out, 4'hF);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst.reg",  reg_out,  4'h0);
        chk("rst.done", cfg_done, 1'b0);
        chk_all("rst");

        load(v_add);
        do_commit();
        load(73'({$urandom, $urandom, $urandom}));
        first_bit = 1'($urandom);
        cfg_commit = 1'b1;
        do_shift(first_bit);
        cfg_commit = 1'b0;
        chk("race.err",  cfg_err,  1'b1);
        chk("race.done", cfg_done, 1'b1);
        add_case(4'b0101, 4'b0110, 1'b1);
        for (int j = 0; j < CB-1; j++) do_shift(1'($urandom));
        chk("scan.first", cfg_out, first_bit);
        chk_all("scan");

        for (int r = 0; r < 20; r++) begin
            load(73'({$urandom, $urandom, $urandom}));
            do_commit();
            for (int c = 0; c < 25; c++) begin
                luts_in    = 16'($urandom);
                ci         = 1'($urandom);
                ce         = 1'($urandom);
                cfg_in     = 1'($urandom);
                cfg_shift  = ($urandom % 4) == 0;
                cfg_commit = ($urandom % 8) == 0;
                rst        = ($urandom % 64) == 0;
                step();
                chk_all("rand");
            end
            cfg_shift = 1'b0; cfg_commit = 1'b0; rst = 1'b0; ce = 1'b0;
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
